// File: rtl/mfp_gauss_sched_if.sv
// Sample-in and result-out handshake bundle for mfp_gauss_sched.
// master = upstream/downstream side, slave = scheduler side.
interface mfp_gauss_sched_if #(
    parameter int InW  = 18,
    parameter int OutW = 18,
    parameter int SW   = 2
);
    logic            in_valid;
    logic            in_ready;
    logic [InW-1:0]  in_data;
    logic            line_start;
    logic            line_end;
    logic            out_valid;
    logic            out_ready;
    logic [OutW-1:0] out_data;
    logic [SW-1:0]   out_scale;
    logic            out_last;

    modport master (
        output in_valid, in_data, line_start, line_end, out_ready,
        input  in_ready, out_valid, out_data, out_scale, out_last
    );

    modport slave (
        input  in_valid, in_data, line_start, line_end, out_ready,
        output in_ready, out_valid, out_data, out_scale, out_last
    );
endinterface

// File: rtl/mfp_gauss_sched.sv
// Window/scale sequencer feeding one shared Gaussian MAC across NSCALE banks.
// Optional tail flush (right-edge replication) enabled by MFP_SCHED_FLUSH_EN.
module mfp_gauss_sched #(
    parameter  int InW     = 18,
    parameter  int OutW    = 18,
    parameter  int TAPS    = 40,
    parameter  int NSCALE  = 4,
    parameter  int MAC_LAT = 0,
    localparam int SW      = (NSCALE > 1) ? $clog2(NSCALE) : 1
) (
    input  logic                clk,
    input  logic                clr,
    mfp_gauss_sched_if.slave    bus,
    output logic [InW*TAPS-1:0] win_out,
    output logic [SW-1:0]       coef_sel,
    input  logic [OutW-1:0]     mac_result,
    output logic                busy
);
    localparam int HALF = TAPS / 2;
    localparam int PW   = $clog2(HALF + 1);
    localparam int LW   = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        CALC,
        HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [InW*TAPS-1:0] win_q, win_d;
    logic [PW-1:0]       prime_q, prime_d;
    logic [SW-1:0]       scale_q, scale_d;
    logic [LW-1:0]       lat_q, lat_d;
    logic                ov_q, ov_d;
    logic [OutW-1:0]     od_q, od_d;
    logic [SW-1:0]       os_q, os_d;
    logic                ol_q, ol_d;
    logic                in_ready_c;

`ifdef MFP_SCHED_FLUSH_EN
    logic                arm_q, arm_d;
    logic [PW-1:0]       fcnt_q, fcnt_d;
`else
    logic                unused_line_end;
    assign unused_line_end = bus.line_end;
`endif

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        prime_d    = prime_q;
        scale_d    = scale_q;
        lat_d      = lat_q;
        ov_d       = ov_q;
        od_d       = od_q;
        os_d       = os_q;
        ol_d       = ol_q;
        in_ready_c = 1'b0;
`ifdef MFP_SCHED_FLUSH_EN
        arm_d      = arm_q;
        fcnt_d     = fcnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    if (bus.line_start) begin
                        win_d   = {TAPS{bus.in_data}};
                        prime_d = PW'(1);
                    end else begin
                        win_d = {win_q[InW*(TAPS-1)-1:0], bus.in_data};
                        if (prime_q < PW'(HALF)) begin
                            prime_d = prime_q + 1'b1;
                        end
                    end
                    scale_d = '0;
                    lat_d   = '0;
                    if (prime_d >= PW'(HALF)) begin
                        state_d = CALC;
                    end
`ifdef MFP_SCHED_FLUSH_EN
                    if (bus.line_end) begin
                        arm_d  = 1'b1;
                        fcnt_d = '0;
                        if (prime_d < PW'(HALF)) begin
                            state_d = PRIME;
                        end
                    end
`endif
                end
            end
            PRIME: begin
`ifdef MFP_SCHED_FLUSH_EN
                // Replicate the last sample to extend the line past its end
                win_d   = {win_q[InW*(TAPS-1)-1:0], win_q[InW-1:0]};
                fcnt_d  = fcnt_q + 1'b1;
                scale_d = '0;
                lat_d   = '0;
                state_d = CALC;
`else
                state_d = IDLE;
`endif
            end
            CALC: begin
                if (lat_q == LW'(MAC_LAT)) begin
                    od_d    = mac_result;
                    os_d    = scale_q;
                    ov_d    = 1'b1;
                    ol_d    = (scale_q == SW'(NSCALE - 1));
                    state_d = HOLD;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    ov_d  = 1'b0;
                    lat_d = '0;
                    if (scale_q != SW'(NSCALE - 1)) begin
                        scale_d = scale_q + 1'b1;
                        state_d = CALC;
                    end else begin
                        scale_d = '0;
                        state_d = IDLE;
`ifdef MFP_SCHED_FLUSH_EN
                        if (arm_q) begin
                            if (fcnt_q == PW'(HALF)) begin
                                arm_d   = 1'b0;
                                prime_d = '0;
                            end else begin
                                state_d = PRIME;
                            end
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            win_q   <= '0;
            prime_q <= '0;
            scale_q <= '0;
            lat_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            os_q    <= '0;
            ol_q    <= 1'b0;
`ifdef MFP_SCHED_FLUSH_EN
            arm_q   <= 1'b0;
            fcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            prime_q <= prime_d;
            scale_q <= scale_d;
            lat_q   <= lat_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            os_q    <= os_d;
            ol_q    <= ol_d;
`ifdef MFP_SCHED_FLUSH_EN
            arm_q   <= arm_d;
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_scale = os_q;
    assign bus.out_last  = ol_q;
    assign win_out       = win_q;
    assign coef_sel      = scale_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_mfp_gauss_sched.sv
// Bench for mfp_gauss_sched: TAPS=8, NSCALE=2, MAC_LAT=1 with a behavioural MAC.
// Directed table, corner sequences, and random lines against a line-level model.
module tb_mfp_gauss_sched;
    localparam int InW     = 18;
    localparam int OutW    = 18;
    localparam int TAPS    = 8;
    localparam int NSCALE  = 2;
    localparam int MAC_LAT = 1;
    localparam int SW      = 1;
    localparam int HALF    = TAPS / 2;

    logic                clk = 1'b0;
    logic                clr;
    logic [InW*TAPS-1:0] win_out;
    logic [SW-1:0]       coef_sel;
    logic [OutW-1:0]     mac_result;
    logic                busy;
    bit                  rnd_rdy, rnd_bit, rdy_fix, sb_en;

    int vectors = 0;
    int errors  = 0;
    int hs_cnt  = 0;

    always #5 clk = ~clk;

    mfp_gauss_sched_if #(.InW(InW), .OutW(OutW), .SW(SW)) bus ();

    mfp_gauss_sched #(
        .InW(InW), .OutW(OutW), .TAPS(TAPS),
        .NSCALE(NSCALE), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus),
        .win_out(win_out),
        .coef_sel(coef_sel),
        .mac_result(mac_result),
        .busy(busy)
    );

    assign bus.out_ready = rnd_rdy ? rnd_bit : rdy_fix;

    // Behavioural MAC: bank0 = 1/8 on every tap, bank1 = ~1.0 on tap 4
    function automatic logic [OutW-1:0] mac_f(input logic [InW*TAPS-1:0] w,
                                              input logic [SW-1:0] s);
        longint acc, x, c;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            x = longint'($signed(w[k*InW +: InW]));
            if (s == 0) c = 16384;
            else        c = (k == 4) ? 131071 : 0;
            acc += x * c;
        end
        return OutW'(acc >>> (InW - 1));
    endfunction

    always @(posedge clk) mac_result <= mac_f(win_out, coef_sel);

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // Reference model: the current line as a list of samples
    typedef struct {
        logic [OutW-1:0] data;
        int              scale;
        bit              last;
    } exp_t;

    int   line_q[$];
    exp_t exp_q[$];

    function automatic logic [OutW-1:0] ref_val(input int n, input int s);
        longint sum;
        int     idx;
        sum = 0;
        if (s == 0) begin
            for (int k = 0; k < TAPS; k++) begin
                idx = n - k;
                if (idx < 0) idx = 0;
                if (idx > line_q.size() - 1) idx = line_q.size() - 1;
                sum += line_q[idx];
            end
            return OutW'(sum >>> 3);
        end
        idx = n - 4;
        if (idx < 0) idx = 0;
        if (idx > line_q.size() - 1) idx = line_q.size() - 1;
        sum = longint'(line_q[idx]) * 131071;
        return OutW'(sum >>> 17);
    endfunction

    task automatic push_pos(input int n);
        exp_t e;
        for (int s = 0; s < NSCALE; s++) begin
            e.data  = ref_val(n, s);
            e.scale = s;
            e.last  = (s == NSCALE - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_en && bus.out_valid && bus.out_ready) begin
            exp_t e;
            hs_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("out_scale", bus.out_scale, e.scale);
                chk("out_last", bus.out_last, e.last);
            end
        end
    end

    task automatic send(input int d, input bit ls, input bit le);
        int t;
        bus.in_valid   = 1'b1;
        bus.in_data    = InW'(d);
        bus.line_start = ls;
        bus.line_end   = le;
        t = 0;
        while (!bus.in_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.line_start = 1'b0;
        bus.line_end   = 1'b0;
        if (ls) line_q.delete();
        line_q.push_back(d);
        if (line_q.size() >= HALF) push_pos(line_q.size() - 1);
`ifdef MFP_SCHED_FLUSH_EN
        if (le) begin
            for (int f = 1; f <= HALF; f++) push_pos(line_q.size() - 1 + f);
        end
`endif
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    function automatic int rnd_sample();
        logic signed [InW-1:0] v;
        v = InW'($urandom);
        return int'(v);
    endfunction

    typedef struct {
        bit              iv;
        bit              ls;
        logic [InW-1:0]  d;
        bit              ordy;
        bit              ov;
        bit              bsy;
        bit              irdy;
        logic [OutW-1:0] od;
        bit              os;
        bit              ol;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int t, hs0, ir;
        logic [OutW-1:0]     d0;
        logic [SW-1:0]       s0;
        logic [InW*TAPS-1:0] w0;

        tbl[0] = '{1, 1, 18'h10000, 1, 0, 0, 1, 18'h0, 0, 0};
        tbl[1] = '{1, 0, 18'h10000, 1, 0, 0, 1, 18'h0, 0, 0};
        tbl[2] = '{1, 0, 18'h10000, 1, 0, 0, 1, 18'h0, 0, 0};
        tbl[3] = '{1, 0, 18'h10000, 1, 0, 1, 0, 18'h0, 0, 0};
        tbl[4] = '{0, 0, 18'h0,     1, 0, 1, 0, 18'h0, 0, 0};
        tbl[5] = '{0, 0, 18'h0,     1, 1, 1, 0, 18'h10000, 0, 0};
        tbl[6] = '{0, 0, 18'h0,     1, 0, 1, 0, 18'h0, 0, 0};
        tbl[7] = '{0, 0, 18'h0,     1, 0, 1, 0, 18'h0, 0, 0};
        tbl[8] = '{0, 0, 18'h0,     1, 1, 1, 0, 18'h0ffff, 1, 1};
        tbl[9] = '{0, 0, 18'h0,     1, 0, 0, 1, 18'h0, 0, 0};

        clr = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.line_start = 1'b0;
        bus.line_end = 1'b0;
        rdy_fix = 1'b1;
        rnd_rdy = 1'b0;
        sb_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_win_zero", win_out == '0, 1);
        chk("rst_coef_sel", coef_sel, 0);
        chk("rst_out_data", bus.out_data, 0);

        for (int i = 0; i < 10; i++) begin
            bus.in_valid   = tbl[i].iv;
            bus.line_start = tbl[i].ls;
            bus.in_data    = tbl[i].d;
            rdy_fix        = tbl[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].irdy);
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].od);
                chk($sformatf("tbl%0d_out_scale", i), bus.out_scale, tbl[i].os);
                chk($sformatf("tbl%0d_out_last", i), bus.out_last, tbl[i].ol);
            end
        end
        bus.in_valid = 1'b0;
        bus.line_start = 1'b0;
        sb_en = 1'b1;

        // Backpressure held in HOLD
        rdy_fix = 1'b0;
        send(32'h08000, 1, 0);
        for (int i = 0; i < 3; i++) send(rnd_sample(), 0, 0);
        t = 0;
        while (!bus.out_valid && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        chk("bp_reach_hold", bus.out_valid, 1);
        d0 = bus.out_data;
        s0 = bus.out_scale;
        w0 = win_out;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_data", bus.out_data, d0);
            chk("bp_out_scale", bus.out_scale, s0);
            chk("bp_win_stable", win_out == w0, 1);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        hs0 = hs_cnt;
        rdy_fix = 1'b1;
        drain("bp_drain");
        chk("bp_handshakes", hs_cnt - hs0, NSCALE);

        // Abort during scale 1 computation
        send(32'h04000, 1, 0);
        for (int i = 0; i < 3; i++) send(rnd_sample(), 0, 0);
        t = 0;
        while (!(busy && coef_sel == 1 && !bus.out_valid) && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        chk("abort_reach_calc1", busy && coef_sel == 1, 1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        exp_q.delete();
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_win_zero", win_out == '0, 1);
        chk("abort_in_ready", bus.in_ready, 1);
        hs0 = hs_cnt;
        send(rnd_sample(), 1, 0);
        for (int i = 0; i < 2; i++) send(rnd_sample(), 0, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_early_out", hs_cnt - hs0, 0);
        send(rnd_sample(), 0, 0);
        drain("abort_reprime");
        chk("abort_results", hs_cnt - hs0, NSCALE);

        // Six-sample line terminated with line_end
        hs0 = hs_cnt;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                send(rnd_sample(), 0, 1);
            end else begin
                send(rnd_sample(), i == 0, 0);
            end
        end
        ir = 0;
        t = 0;
        while (busy && t < 400) begin
            if (bus.in_ready) ir++;
            @(posedge clk); #1;
            t++;
        end
        chk("flush_in_ready_low", ir, 0);
        drain("flush_drain");
`ifdef MFP_SCHED_FLUSH_EN
        chk("flush_results", hs_cnt - hs0, 14);
`else
        chk("flush_results", hs_cnt - hs0, 6);
`endif

        // Random lines with random gaps and backpressure
        rnd_rdy = 1'b1;
        for (int l = 0; l < 25; l++) begin
            int len;
            len = $urandom_range(4, 10);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send(rnd_sample(), i == 0, i == len - 1);
            end
        end
        drain("rand_drain");
        rnd_rdy = 1'b0;
        rdy_fix = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rand_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
